// File: rtl/emesh_rd_responder.sv
// emesh_rd_responder
//   Emesh read target placed downstream of the AXI slave read stage. Each
//   accepted read looks up a local synchronous memory and comes back as an
//   emesh write. The response dstaddr is the request srcaddr, so the
//   read-tag/last bits reach the AXI slave data FIFO unchanged.
//
//   Ports
//     eclk, reset             clock and synchronous active-high reset
//     emesh_*_inb             incoming read request; emesh_data_inb is ignored
//     emesh_rd_wait_outb      request stall, from registered occupancy only
//     emesh_*_outb            outgoing response (write=1, addresses swapped)
//     emesh_wr_wait_inb       response stall from the consumer
//     mem_rd_en/mem_addr      read strobe and word address to the memory
//     mem_rd_data             memory data, valid one cycle after mem_rd_en
//     err_flags               sticky: [0] out-of-window read, [1] write seen
module emesh_rd_responder #(
  parameter int          MAW       = 10,
  parameter logic [31:0] BASE_ADDR = 32'h8080_0000,
  parameter int          RFW       = 2
) (
  input  logic           eclk,
  input  logic           reset,
  input  logic           emesh_access_inb,
  input  logic           emesh_write_inb,
  input  logic [1:0]     emesh_datamode_inb,
  input  logic [3:0]     emesh_ctrlmode_inb,
  input  logic [31:0]    emesh_dstaddr_inb,
  input  logic [31:0]    emesh_srcaddr_inb,
  input  logic [31:0]    emesh_data_inb,
  output logic           emesh_rd_wait_outb,
  output logic           emesh_access_outb,
  output logic           emesh_write_outb,
  output logic [1:0]     emesh_datamode_outb,
  output logic [3:0]     emesh_ctrlmode_outb,
  output logic [31:0]    emesh_dstaddr_outb,
  output logic [31:0]    emesh_srcaddr_outb,
  output logic [31:0]    emesh_data_outb,
  input  logic           emesh_wr_wait_inb,
  output logic           mem_rd_en,
  output logic [MAW-1:0] mem_addr,
  input  logic [31:0]    mem_rd_data,
  output logic [1:0]     err_flags
);

  localparam int             DATA_W  = 32;
  localparam int             DEPTH   = 2 ** RFW;
  localparam logic [RFW:0]   CNT_MAX = (RFW+1)'(DEPTH);
  localparam logic [RFW+1:0] OCC_MAX = (RFW+2)'(DEPTH);

  typedef struct packed {
    logic [1:0]        datamode;
    logic [3:0]        ctrlmode;
    logic [31:0]       dstaddr;
    logic [31:0]       srcaddr;
    logic [DATA_W-1:0] data;
  } rsp_t;

  // Right-align the addressed byte/halfword; word and dword pass through.
  function automatic logic [DATA_W-1:0] align_rd(input logic [DATA_W-1:0] w,
                                                  input logic [1:0]        dm,
                                                  input logic [1:0]        a);
    logic [DATA_W-1:0] r;
    r = w;
    case (dm)
      2'b00: begin
        case (a)
          2'b00:   r = {24'b0, w[7:0]};
          2'b01:   r = {24'b0, w[15:8]};
          2'b10:   r = {24'b0, w[23:16]};
          default: r = {24'b0, w[31:24]};
        endcase
      end
      2'b01:   r = a[1] ? {16'b0, w[31:16]} : {16'b0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  logic unused_inb;
  assign unused_inb = ^emesh_data_inb;

  // ---- stage p0: accept, window check, memory read issue ----
  logic acc_p0, rd_p0, wr_p0, in_win_p0;
  assign acc_p0    = emesh_access_inb & ~emesh_rd_wait_outb;
  assign rd_p0     = acc_p0 & ~emesh_write_inb;
  assign wr_p0     = acc_p0 &  emesh_write_inb;
  assign in_win_p0 = (emesh_dstaddr_inb[31:MAW+2] == BASE_ADDR[31:MAW+2]);
  assign mem_rd_en = rd_p0 & in_win_p0;
  assign mem_addr  = emesh_dstaddr_inb[MAW+1:2];

  logic        vld_p1, oow_p1;
  logic [1:0]  dm_p1;
  logic [3:0]  cm_p1;
  logic [31:0] dst_p1, src_p1;

  always_ff @(posedge eclk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= rd_p0;
  end

  always_ff @(posedge eclk) begin
    if (rd_p0) begin
      dm_p1  <= emesh_datamode_inb;
      cm_p1  <= emesh_ctrlmode_inb;
      dst_p1 <= emesh_dstaddr_inb;
      src_p1 <= emesh_srcaddr_inb;
      oow_p1 <= ~in_win_p0;
    end
  end

  always_ff @(posedge eclk) begin
    if (reset) err_flags <= 2'b00;
    else begin
      if (rd_p0 & ~in_win_p0) err_flags[0] <= 1'b1;
      if (wr_p0)              err_flags[1] <= 1'b1;
    end
  end

  // ---- stage p1: memory data arrives, align, bypass or enqueue ----
  rsp_t rsp_p1;
  always_comb begin
    rsp_p1          = '0;
    rsp_p1.datamode = dm_p1;
    rsp_p1.ctrlmode = cm_p1;
    rsp_p1.dstaddr  = src_p1;
    rsp_p1.srcaddr  = dst_p1;
    rsp_p1.data     = oow_p1 ? '0 : align_rd(mem_rd_data, dm_p1, dst_p1[1:0]);
  end

  rsp_t           fifo_mem [DEPTH];
  logic [RFW-1:0] wr_ptr, rd_ptr;
  logic [RFW:0]   fifo_cnt;
  logic           fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic           vld_p2, out_load;
  rsp_t           rsp_p2;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_MAX);
  assign out_load   = ~vld_p2 | ~emesh_wr_wait_inb;
  // The output register takes the FIFO head first so older entries always
  // leave before the pipeline; the pipeline bypasses only an empty FIFO.
  assign fifo_pop   = out_load & ~fifo_empty;
  assign fifo_push  = vld_p1 & ~(out_load & fifo_empty);

  always_ff @(posedge eclk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + RFW'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + RFW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (RFW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (RFW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge eclk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= rsp_p1;
  end

  // The credit scheme guarantees space; a push into a full FIFO is a bug.
  always_ff @(posedge eclk) begin
    if (!reset) assert (!(fifo_push && fifo_full));
  end

  // ---- stage p2: response register ----
  always_ff @(posedge eclk) begin
    if (reset)         vld_p2 <= 1'b0;
    else if (out_load) vld_p2 <= ~fifo_empty | vld_p1;
  end

  always_ff @(posedge eclk) begin
    if (out_load & (~fifo_empty | vld_p1))
      rsp_p2 <= fifo_empty ? rsp_p1 : fifo_mem[rd_ptr];
  end

  // Occupancy counts every slot a response may still need, so stalling at
  // DEPTH keeps the FIFO from ever being pushed while full.
  logic [RFW+1:0] occ;
  assign occ = (RFW+2)'(vld_p1) + (RFW+2)'(vld_p2) + (RFW+2)'(fifo_cnt);
  assign emesh_rd_wait_outb = reset | (occ >= OCC_MAX);

  assign emesh_access_outb   = vld_p2 & ~reset;
  assign emesh_write_outb    = 1'b1;
  assign emesh_datamode_outb = rsp_p2.datamode;
  assign emesh_ctrlmode_outb = rsp_p2.ctrlmode;
  assign emesh_dstaddr_outb  = rsp_p2.dstaddr;
  assign emesh_srcaddr_outb  = rsp_p2.srcaddr;
  assign emesh_data_outb     = rsp_p2.data;

endmodule

// File: doc/emesh_rd_responder.md
Name: emesh_rd_responder

Overview:
- Emesh-side read target that sits directly downstream of the AXI slave read stage.
- Accepts emesh read transactions, reads a local synchronous memory, and returns each result as an emesh write transaction.
- The returned dstaddr is the request's srcaddr, so the read-tag/last bits come back unchanged to the AXI slave's data FIFO.
- Handles credit-based backpressure, bounded buffering and data right-alignment.

Parameters:
- MAW, 10, memory word-address width; memory covers 2**MAW 32-bit words.
- BASE_ADDR, 32'h8080_0000, base byte address of the memory window; the low MAW+2 bits must be zero.
- RFW, 2, response FIFO address width; FIFO depth is 2**RFW.

Ports:
- eclk  input  1  emesh clock; all logic is on its rising edge
- reset  input  1  synchronous, active-high reset
- emesh_access_inb  input  1  request valid
- emesh_write_inb  input  1  request is a write (not serviced)
- emesh_datamode_inb  input  2  00 byte, 01 hword, 10 word, 11 dword (treated as word)
- emesh_ctrlmode_inb  input  4  ctrlmode, echoed in the response
- emesh_dstaddr_inb  input  32  read byte address
- emesh_srcaddr_inb  input  32  return address / tag
- emesh_data_inb  input  32  ignored
- emesh_rd_wait_outb  output  1  request stall
- emesh_access_outb  output  1  response valid
- emesh_write_outb  output  1  constant 1
- emesh_datamode_outb  output  2  echoed datamode
- emesh_ctrlmode_outb  output  4  echoed ctrlmode
- emesh_dstaddr_outb  output  32  request srcaddr
- emesh_srcaddr_outb  output  32  request dstaddr
- emesh_data_outb  output  32  aligned read data
- emesh_wr_wait_inb  input  1  response stall from consumer
- mem_rd_en  output  1  memory read strobe
- mem_addr  output  MAW  word address
- mem_rd_data  input  32  memory data, valid exactly one cycle after mem_rd_en
- err_flags  output  2  sticky: bit0 out-of-window read, bit1 write received

Behaviour:
- Accept condition: emesh_access_inb=1 and emesh_rd_wait_outb=0.
  - Read: accepted in cycle N.
  - Write: consumed in cycle N and discarded; sets err_flags[1]; nothing enters the pipeline.
- Window check: the read is in-window when dstaddr[31:MAW+2] == BASE_ADDR[31:MAW+2].
  - In-window: in cycle N, mem_rd_en=1 and mem_addr=dstaddr[MAW+1:2].
  - Out-of-window: mem_rd_en stays 0, response data is forced to 0, err_flags[0] is set.
- Pipeline register (pipe_valid) captures the request fields at the end of cycle N.
- Alignment in cycle N+1 uses a = saved dstaddr[1:0] and mem_rd_data:
  - byte: {24'b0, byte a}
  - hword: a[1] selects the upper or lower 16 bits, zero-extended
  - word/dword: full word
- Response register (out_valid, which drives emesh_access_outb):
  - Loads when out_valid=0, or when out_valid=1 and wr_wait=0.
  - Source is the FIFO head if the FIFO is non-empty, otherwise the pipeline directly (bypass).
  - When the bypass source cannot load, the pipeline entry is written into the FIFO.
  - Unstalled latency: accept in N gives emesh_access_outb=1 in cycle N+2.
- Ordering: responses are strictly in request order; a newer pipeline entry never overtakes the FIFO.
- Output hold: while emesh_access_outb=1 and emesh_wr_wait_inb=1, every emesh_*_outb field is held stable. A transfer completes on a cycle where access=1 and wait=0.
- Credit:
  - occupancy = pipe_valid + fifo_count + out_valid
  - emesh_rd_wait_outb = reset | (occupancy >= 2**RFW), computed combinationally from registered state only (no dependence on the inputs in the same cycle)
  - The FIFO can never overflow; a push with the FIFO full is a design error, checked by an assertion.
- Simultaneous events in one cycle (response transfer, FIFO pop into the output register, pipeline push, new accept) all happen together; the counters are updated net.
- Reset, including mid-burst:
  - Next edge: pipe_valid=0, FIFO empty, out_valid=0, err_flags=0; in-flight responses are dropped.
  - While reset=1: emesh_access_outb=0, mem_rd_en=0, emesh_rd_wait_outb=1.
  - Data/address outputs are don't-care until the first response.

Test Plan:
- Single word read: dstaddr=BASE_ADDR+0x10, srcaddr=0x1234_5679, memory word 4 = 0xA1B2C3D4 → mem_addr=4 in cycle N; emesh_access_outb in N+2 with dstaddr_outb=0x1234_5679, srcaddr_outb=BASE_ADDR+0x10, data=0xA1B2C3D4, write=1.
- Alignment: byte reads at offsets 0–3 of 0xA1B2C3D4 → data 0xD4, 0xC3, 0xB2, 0xA1. Hword reads at offsets 0 and 2 → 0xC3D4, 0xA1B2.
- Backpressure (RFW=2): hold wr_wait=1 and issue back-to-back reads → exactly 4 accepted, then rd_wait=1. Release wr_wait → 4 responses in request order, outputs stable while stalled, rd_wait drops the cycle after occupancy falls below 4.
- Out-of-window read at 0x0000_0100 → mem_rd_en stays 0; response data=0; err_flags=2'b01. A write request → no response; err_flags=2'b11.
- Reset asserted with 3 responses queued → next cycle access_outb=0 and err_flags=0; after release the first new read returns correctly with latency 2.
- Random stress: 2000 random reads with random wr_wait at 50% → every response matches a scoreboard (order, tag, data); no FIFO overflow assertion fires.
